// File: rtl/buffer_readout_pkg.sv
// Shared types for the buffer readout block: the drain FSM state encoding.
package buffer_readout_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/readout_counter.sv
// Nested channel/stage counter for the snapshot drain. Channel is the inner
// index, stage the outer; `last` flags the final (chan, stage) pair.
module readout_counter #(
    parameter int numChannels = 16,
    parameter int depth       = 5
) (
    input  logic                           clk,
    input  logic                           rstb,
    input  logic                           clear,
    input  logic                           advance,
    output logic [$clog2(numChannels)-1:0] chan,
    output logic [$clog2(depth)-1:0]       stage,
    output logic                           last
);
    localparam int CW = $clog2(numChannels);
    localparam int SW = $clog2(depth);
    localparam logic [CW-1:0] CHAN_MAX  = CW'(numChannels - 1);
    localparam logic [SW-1:0] STAGE_MAX = SW'(depth - 1);

    logic [CW-1:0] chan_q, chan_d;
    logic [SW-1:0] stage_q, stage_d;
    logic          chan_last, stage_last;

    always_comb begin
        chan_last  = (chan_q == CHAN_MAX);
        stage_last = (stage_q == STAGE_MAX);
        chan_d     = chan_q;
        stage_d    = stage_q;
        if (clear) begin
            chan_d  = '0;
            stage_d = '0;
        end else if (advance) begin
            if (chan_last) begin
                chan_d  = '0;
                // Stage wraps too after the final word so the pair idles at (0,0).
                stage_d = stage_last ? '0 : stage_q + 1'b1;
            end else begin
                chan_d = chan_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            chan_q  <= '0;
            stage_q <= '0;
        end else begin
            chan_q  <= chan_d;
            stage_q <= stage_d;
        end
    end

    assign chan  = chan_q;
    assign stage = stage_q;
    assign last  = chan_last & stage_last;

endmodule

// File: rtl/buffer_readout.sv
// Captures a full snapshot of a channel x stage pipeline on trigger and drains
// it one word per accepted handshake, channel-inner / stage-outer.
module buffer_readout
    import buffer_readout_pkg::*;
#(
    parameter int numChannels = 16,
    parameter int bitwidth    = 8,
    parameter int depth       = 5
) (
    input  logic                                           clk,
    input  logic                                           rstb,
    input  logic [numChannels-1:0][depth-1:0][bitwidth-1:0] buffer,
    input  logic                                           trigger,
    input  logic                                           clear_overrun,
    input  logic                                           out_ready,
    output logic                                           out_valid,
    output logic [bitwidth-1:0]                            out_data,
    output logic [$clog2(numChannels)-1:0]                 out_chan,
    output logic [$clog2(depth)-1:0]                       out_stage,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           overrun
);
    localparam int CW = $clog2(numChannels);
    localparam int SW = $clog2(depth);

    state_e state_q, state_d;
    logic   out_valid_q, out_valid_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   overrun_q, overrun_d;
    logic   capture, xfer, last_word;

    logic [numChannels-1:0][depth-1:0][bitwidth-1:0] snap_q, snap_d;
    logic [CW-1:0] chan;
    logic [SW-1:0] stage;

    readout_counter #(
        .numChannels(numChannels),
        .depth      (depth)
    ) u_cnt (
        .clk    (clk),
        .rstb   (rstb),
        .clear  (capture),
        .advance(xfer),
        .chan   (chan),
        .stage  (stage),
        .last   (last_word)
    );

    always_comb begin
        xfer        = out_valid_q & out_ready;
        capture     = (state_q == ST_IDLE) & trigger;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        snap_d      = capture ? buffer : snap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d     = ST_DRAIN;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (xfer && last_word) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A trigger while draining always flags, even if a clear arrives with it.
        if (state_q == ST_DRAIN && trigger) overrun_d = 1'b1;
        else if (clear_overrun)             overrun_d = 1'b0;
        else                                overrun_d = overrun_q;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    // Snapshot storage carries no reset; it is only meaningful while draining.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign out_chan  = chan;
    assign out_stage = stage;
    assign out_data  = snap_q[chan][stage];

endmodule

// File: tb/tb_buffer_readout.sv
// Directed + randomized bench for buffer_readout against a queue-based model
// of the expected word stream, done pulse and overrun flag.
module tb_buffer_readout;
    localparam int N = 16;
    localparam int D = 5;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rstb, trigger, clear_overrun, out_ready;
    logic [N-1:0][D-1:0][W-1:0] buf_in;
    logic                  out_valid, busy, done, overrun;
    logic [W-1:0]          out_data;
    logic [$clog2(N)-1:0]  out_chan;
    logic [$clog2(D)-1:0]  out_stage;

    buffer_readout #(.numChannels(N), .bitwidth(W), .depth(D)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .buffer       (buf_in),
        .trigger      (trigger),
        .clear_overrun(clear_overrun),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_chan     (out_chan),
        .out_stage    (out_stage),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           c;
        int           s;
    } word_t;

    word_t exp_q[$];
    bit    m_done, m_ovr;
    int    n_cmp = 0;
    int    n_err = 0;
    int    xfers, dones;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pattern();
        for (int c = 0; c < N; c++)
            for (int s = 0; s < D; s++)
                buf_in[c][s] = W'(8 * c + s);
    endtask

    task automatic set_random();
        for (int c = 0; c < N; c++)
            for (int s = 0; s < D; s++)
                buf_in[c][s] = W'($urandom);
    endtask

    // Model of one rising edge, using the inputs as the DUT samples them.
    task automatic model_edge();
        bit was_busy;
        was_busy = (exp_q.size() > 0);
        if (!rstb) begin
            exp_q.delete();
            m_done = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (was_busy && trigger) m_ovr = 1'b1;
            else if (clear_overrun)  m_ovr = 1'b0;
            if (was_busy) begin
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    xfers++;
                    if (exp_q.size() == 0) m_done = 1'b1;
                end
            end else if (trigger) begin
                for (int s = 0; s < D; s++)
                    for (int c = 0; c < N; c++)
                        exp_q.push_back('{buf_in[c][s], c, s});
            end
        end
    endtask

    task automatic check_all();
        bit v;
        v = (exp_q.size() > 0);
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("busy",      32'(busy),      32'(v));
        chk("done",      32'(done),      32'(m_done));
        chk("overrun",   32'(overrun),   32'(m_ovr));
        if (v) begin
            chk("out_data",  32'(out_data),  32'(exp_q[0].d));
            chk("out_chan",  32'(out_chan),  32'(exp_q[0].c));
            chk("out_stage", 32'(out_stage), 32'(exp_q[0].s));
        end
        if (done) dones++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rstb = 1'b0; trigger = 1'b0; clear_overrun = 1'b0; out_ready = 1'b0;
        xfers = 0; dones = 0; m_done = 1'b0; m_ovr = 1'b0;
        set_pattern();
        cyc(); cyc();
        chk("rst_chan",  32'(out_chan),  32'd0);
        chk("rst_stage", 32'(out_stage), 32'd0);
        rstb = 1'b1;
        cyc();

        // Full drain with ready held high.
        out_ready = 1'b1; dones = 0; xfers = 0;
        trigger = 1'b1; cyc(); trigger = 1'b0;
        chk("first_chan", 32'(out_chan), 32'd0);
        chk("first_data", 32'(out_data), 32'd0);
        repeat (82) cyc();
        chk("t1_done_cnt", 32'(dones), 32'd1);
        chk("t1_words",    32'(xfers), 32'd80);

        // Buffer changes after capture must not leak into the snapshot.
        trigger = 1'b1; cyc(); trigger = 1'b0;
        for (int c = 0; c < N; c++)
            for (int s = 0; s < D; s++)
                buf_in[c][s] = 8'hFF;
        repeat (82) cyc();
        set_pattern();

        // Random backpressure.
        xfers = 0;
        trigger = 1'b1; cyc(); trigger = 1'b0;
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_words", 32'(xfers), 32'd80);
        chk("bp_idle",  32'(out_valid), 32'd0);

        // Overrun: trigger mid-drain and on the final transfer.
        trigger = 1'b1; cyc(); trigger = 1'b0;
        repeat (40) cyc();
        chk("ovr_pre", 32'(out_chan + 16 * out_stage), 32'd40);
        trigger = 1'b1; cyc(); trigger = 1'b0;
        chk("ovr_mid", 32'(overrun), 32'd1);
        for (int i = 0; i < 100 && exp_q.size() != 1; i++) cyc();
        trigger = 1'b1; cyc(); trigger = 1'b0;
        chk("ovr_norestart", 32'(out_valid), 32'd0);
        cyc();
        chk("ovr_still_idle", 32'(out_valid), 32'd0);
        clear_overrun = 1'b1; cyc(); clear_overrun = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);
        trigger = 1'b1; cyc(); trigger = 1'b0;
        chk("fresh_valid", 32'(out_valid), 32'd1);
        repeat (82) cyc();

        // Reset mid-drain with a simultaneous trigger.
        trigger = 1'b1; cyc(); trigger = 1'b0;
        repeat (30) cyc();
        dones = 0;
        rstb = 1'b0; trigger = 1'b1; cyc(); rstb = 1'b1; trigger = 1'b0;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy",  32'(busy),      32'd0);
        cyc();
        chk("rst_mid_nodone", 32'(dones), 32'd0);
        trigger = 1'b1; cyc(); trigger = 1'b0;
        chk("restart_chan",  32'(out_chan),  32'd0);
        chk("restart_stage", 32'(out_stage), 32'd0);
        repeat (82) cyc();

        // Trigger held high: back-to-back snapshots with one idle cycle.
        dones = 0;
        trigger = 1'b1;
        repeat (250) cyc();
        chk("hold_dones",   32'(dones),   32'd3);
        chk("hold_overrun", 32'(overrun), 32'd1);
        trigger = 1'b0;
        repeat (90) cyc();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rstb          = ($urandom_range(0, 199) != 0);
            trigger       = ($urandom_range(0, 19) == 0);
            clear_overrun = ($urandom_range(0, 9) == 0);
            out_ready     = 1'($urandom_range(0, 1));
            set_random();
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
